mem_loader: RTL

- Boot-time loader that sits directly upstream of memory_block's write port.
- Accepts a framed byte stream from a serial receiver (valid/ready) and assembles big-endian 16-bit words.
- Writes the words to consecutive memory addresses and verifies a trailing 16-bit checksum.
- Reports done or error; the core is held off until done.

---
 rtl/mem_loader_pkg.sv | 35 +++
 rtl/mem_loader_byte_pair.sv | 26 ++
 rtl/mem_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
package mem_loader_pkg;

    // Frame field sizes in bytes (length header and checksum trailer)
    localparam int LEN_BYTES = 2;
    localparam int SUM_BYTES = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_SUM_HI,
        ST_SUM_LO,
        ST_DONE,
        ST_ERROR
    } state_t;

    // States in which a frame is being received (byte_ready / busy)
    function automatic logic is_rx_state(input state_t s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_SUM_HI, ST_SUM_LO};
    endfunction

    // States that take the high byte of a big-endian field
    function automatic logic is_hi_state(input state_t s);
        return s inside {ST_LEN_HI, ST_DATA_HI, ST_SUM_HI};
    endfunction

    // States that take the low byte and complete a field
    function automatic logic is_lo_state(input state_t s);
        return s inside {ST_LEN_LO, ST_DATA_LO, ST_SUM_LO};
    endfunction

endpackage

// File: rtl/mem_loader_byte_pair.sv
// Big-endian byte pair assembler: keeps the high byte and presents the full
// word combinationally on the cycle the low byte is accepted.
module byte_pair_assembler (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_hi_take,
    input  logic        i_lo_take,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_word,
    output logic        o_word_valid
);

    logic [7:0] r_hi;

    // Latch the high byte when it is accepted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_hi <= 8'h00;
        else if (i_hi_take)
            r_hi <= i_byte;
    end

    assign o_word       = {r_hi, i_byte};
    assign o_word_valid = i_lo_take;

endmodule

// File: rtl/mem_loader.sv
// Boot-time loader: parses a LEN / DATA... / SUM byte frame, writes the data
// words to consecutive addresses and checks the trailing 16-bit sum.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'hFFFF,
    parameter int          WIDTH     = 16        // only 16 is supported
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             write_enable,
    output logic [15:0]      write_address,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_written
);

    state_t             r_state;
    logic [15:0]        r_remaining;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   r_data;
    logic [15:0]        r_addr;
    logic [15:0]        r_words;
    logic               r_we;
    logic               r_done;
    logic               r_error;

    logic                   w_accept;
    logic                   w_hi_take;
    logic                   w_lo_take;
    logic [15:0]            w_word;
    logic                   w_word_valid;
    logic [LEN_BYTES*8-1:0] w_len;
    logic [SUM_BYTES*8-1:0] w_sum_rx;
    logic                   w_overlength;

    assign w_accept  = byte_valid && byte_ready;
    assign w_hi_take = w_accept && is_hi_state(r_state);
    assign w_lo_take = w_accept && is_lo_state(r_state);

    byte_pair_assembler u_asm (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_hi_take    (w_hi_take),
        .i_lo_take    (w_lo_take),
        .i_byte       (byte_in),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign w_len    = w_word;
    assign w_sum_rx = w_word;
    // Widened compare so MAX_WORDS = FFFF simply never rejects
    assign w_overlength = {1'b0, w_len} > {1'b0, MAX_WORDS};

    // Frame FSM with address counter, running sum and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= 16'h0000;
            r_sum       <= '0;
            r_data      <= '0;
            r_addr      <= BASE_ADDR;
            r_words     <= 16'h0000;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Address advances once the write cycle has been presented
            if (r_we)
                r_addr <= r_addr + 16'd1;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state <= ST_LEN_HI;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_words <= 16'h0000;
                        r_sum   <= '0;
                        r_addr  <= BASE_ADDR;
                    end
                end
                ST_LEN_HI: if (w_hi_take) r_state <= ST_LEN_LO;
                ST_LEN_LO: begin
                    if (w_word_valid) begin
                        if (w_overlength) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else if (w_len == 16'h0000) begin
                            r_state <= ST_SUM_HI;
                        end else begin
                            r_remaining <= w_len;
                            r_state     <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: if (w_hi_take) r_state <= ST_DATA_LO;
                ST_DATA_LO: begin
                    if (w_word_valid) begin
                        r_data      <= w_word;
                        r_we        <= 1'b1;
                        r_words     <= r_words + 16'd1;
                        r_sum       <= r_sum + w_word;
                        r_remaining <= r_remaining - 16'd1;
                        r_state     <= (r_remaining == 16'd1) ? ST_SUM_HI : ST_DATA_HI;
                    end
                end
                ST_SUM_HI: if (w_hi_take) r_state <= ST_SUM_LO;
                ST_SUM_LO: begin
                    if (w_word_valid) begin
                        if (w_sum_rx == r_sum) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_ready    = is_rx_state(r_state);
    assign busy          = is_rx_state(r_state);
    assign write_enable  = r_we;
    assign write_address = r_addr;
    assign data_in       = r_data;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words;

endmodule
